div_request_arbiter: RTL and testbench
======================================

Name: div_request_arbiter

Overview:
- Shares one long-division unit (divider datapath plus its start/done/error controller) among NREQ requesters.
- Arbitration is round-robin. The block captures the winner's operands, issues a single start pulse to the divider, waits for done, and routes quotient/remainder/error back to the winner.
- A watchdog aborts a divide that never completes.
- Sits between client blocks and the divider instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, dividend/divisor/quotient/remainder width
- TIMEOUT, 64, max cycles in WAIT_DONE before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, level; held until gnt seen
- dividend_in  in  NREQ*WIDTH  packed operands, slice i = requester i
- divisor_in  in  NREQ*WIDTH  packed operands, slice i = requester i
- gnt  out  NREQ  one-hot, 1-cycle pulse; operands captured
- resp_valid  out  NREQ  one-hot, 1-cycle pulse; response buses valid
- resp_quotient  out  WIDTH  shared result bus
- resp_remainder  out  WIDTH  shared result bus
- resp_error  out  1  divide-by-zero or timeout
- resp_timeout  out  1  response caused by watchdog abort
- busy  out  1  high in any state except IDLE
- div_start  out  1  1-cycle start pulse to divider
- div_abort  out  1  1-cycle pulse; divider controller must return to its wait state
- div_dividend  out  WIDTH  registered operand, stable ISSUE..RESPOND
- div_divisor  out  WIDTH  registered operand, stable ISSUE..RESPOND
- div_done  in  1  divider finished (1-cycle pulse)
- div_error  in  1  divider error (divisor zero), valid with div_done
- div_quotient  in  WIDTH  valid with div_done
- div_remainder  in  WIDTH  valid with div_done

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, timer=0.
  - All outputs 0, including the result buses and operand registers.
- All outputs are registered; no combinational input-to-output path.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE:
  - If any req bit is set, select the first set index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - On that edge: latch its operands into div_dividend/div_divisor, latch owner index, set gnt[owner]=1, go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[owner]=1, div_start=1, timer cleared. Next state WAIT_DONE.
- WAIT_DONE:
  - If div_done=1: latch div_quotient, div_remainder and div_error into the resp buses; resp_timeout=0; go to RESPOND.
  - Else if timer==TIMEOUT-1: div_abort=1 next cycle; resp_quotient=0, resp_remainder=0, resp_error=1, resp_timeout=1; go to RESPOND.
  - Else timer++.
  - div_done and timeout in the same cycle: div_done wins.
- RESPOND (1 cycle):
  - resp_valid[owner]=1; rr_ptr <= (owner+1) mod NREQ; next state IDLE.
  - Result buses hold their value until the next response.
- Throughput: at most one operation outstanding. Minimum request-to-response is 4 + divider latency cycles. Re-arbitration happens in IDLE, never in RESPOND.
- req is ignored outside IDLE. A requester that drops req mid-operation still receives resp_valid.
- Any req bit, including the winner's, may remain high at IDLE; the rotation keeps arbitration fair.
- Divide-by-zero is not pre-checked by the arbiter; div_error is passed straight through as resp_error.
- div_done outside WAIT_DONE is ignored.
- Reset asserted mid-operation: immediate return to IDLE, no resp_valid, rr_ptr=0, pending operation lost.
- rr_ptr wraps NREQ-1 -> 0.
- timer width is clog2(TIMEOUT)+1 and it never wraps.

Test Plan:
- Single request. req[2]=1 with 100/7.
  - gnt[2] pulses once; div_start pulses next to gnt.
  - resp_valid[2] with quotient=14, remainder=2, resp_error=0; rr_ptr=3.
- Simultaneous requests. req[0] and req[1] both set from reset (rr_ptr=0).
  - Requester 0 is served first, then requester 1.
  - Repeat with rr_ptr=1: requester 1 is served first.
- Saturation fairness. All 4 requesters hold req continuously for 8 operations.
  - Grant order is 0,1,2,3,0,1,2,3; gnt and resp_valid are one-hot; busy never drops between ops except the 1-cycle IDLE.
- Divide by zero. req[3] with 55/0; divider model returns div_error.
  - resp_valid[3], resp_error=1, resp_timeout=0.
- Timeout. Divider model never asserts done, TIMEOUT=16.
  - div_abort pulses exactly 16 cycles after div_start.
  - resp_error=1, resp_timeout=1, quotient=0; next request served normally.
- Reset mid-WAIT_DONE. reset=0 asynchronously.
  - All outputs 0 immediately, no resp_valid.
  - After release, req[1] is granted with rr_ptr=0 priority.

Source files
------------

// File: rtl/div_request_arbiter_if.sv
// ----------------------------------------------------------------------------
// div_request_arbiter_if
// Bundles the client-side request/response signals and the divider-side
// start/done signals of the division arbiter.
//
// Handshake semantics:
//   * req[i] is a level request.  The client holds it, with its operands
//     stable in slice i of dividend_in/divisor_in, until it sees gnt[i].
//     gnt[i] is a one-cycle pulse; it means the operands have been captured.
//   * resp_valid[i] is a one-cycle pulse with no backpressure.  The shared
//     resp_* buses are valid in that cycle and hold until the next response.
//   * div_start is a one-cycle pulse.  The divider answers with a one-cycle
//     div_done, with div_error/div_quotient/div_remainder valid alongside.
//     A one-cycle div_abort tells the divider to drop the current operation.
//
// Modports:
//   slave  - the arbiter's view (drives gnt, resp_*, busy, div_start, ...)
//   master - the environment's view (clients plus the divider)
// ----------------------------------------------------------------------------
interface div_request_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] dividend_in;
   logic [NREQ*WIDTH-1:0] divisor_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       resp_valid;
   logic [WIDTH-1:0]      resp_quotient;
   logic [WIDTH-1:0]      resp_remainder;
   logic                  resp_error;
   logic                  resp_timeout;
   logic                  busy;
   logic                  div_start;
   logic                  div_abort;
   logic [WIDTH-1:0]      div_dividend;
   logic [WIDTH-1:0]      div_divisor;
   logic                  div_done;
   logic                  div_error;
   logic [WIDTH-1:0]      div_quotient;
   logic [WIDTH-1:0]      div_remainder;

   modport slave (
      input  req, dividend_in, divisor_in,
      input  div_done, div_error, div_quotient, div_remainder,
      output gnt, resp_valid, resp_quotient, resp_remainder,
      output resp_error, resp_timeout, busy,
      output div_start, div_abort, div_dividend, div_divisor
   );

   modport master (
      output req, dividend_in, divisor_in,
      output div_done, div_error, div_quotient, div_remainder,
      input  gnt, resp_valid, resp_quotient, resp_remainder,
      input  resp_error, resp_timeout, busy,
      input  div_start, div_abort, div_dividend, div_divisor
   );
endinterface

// File: rtl/div_request_arbiter.sv
// ----------------------------------------------------------------------------
// div_request_arbiter
// Shares one long-division unit among NREQ requesters.  A round-robin pick
// in IDLE captures the winner's operands, a single start pulse is issued,
// and the divider's result (or a watchdog abort) is routed back to the winner.
//
// Ports:
//   clk_i     - system clock, rising edge
//   reset_ni  - asynchronous active-low reset
//   bus       - client request/response and divider signals (slave modport)
//   state_o   - current FSM state (0 IDLE, 1 ISSUE, 2 WAIT_DONE, 3 RESPOND)
//   rr_ptr_o  - current round-robin priority pointer
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module div_request_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   div_request_arbiter_if.slave      bus,
   output logic [1:0]                state_o,
   output logic [$clog2(NREQ)-1:0]   rr_ptr_o
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] NREQ_C   = CW'(NREQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESPOND   = 2'd3
   } state_t;

   state_t            state_q;
   logic [PW-1:0]     rr_ptr_q;
   logic [PW-1:0]     owner_q;
   logic [TW-1:0]     timer_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   resp_valid_q;
   logic [WIDTH-1:0]  resp_quotient_q;
   logic [WIDTH-1:0]  resp_remainder_q;
   logic              resp_error_q;
   logic              resp_timeout_q;
   logic              busy_q;
   logic              div_start_q;
   logic              div_abort_q;
   logic [WIDTH-1:0]  div_dividend_q;
   logic [WIDTH-1:0]  div_divisor_q;

   // Round-robin pick: scan rr_ptr, rr_ptr+1, ... (mod NREQ), first set wins.
   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic [CW-1:0]     cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + CW'(k);
         if (cand >= NREQ_C) begin
            cand = cand - NREQ_C;
         end
         if (!win_found && bus.req[cand[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q          <= IDLE;
         rr_ptr_q         <= '0;
         owner_q          <= '0;
         timer_q          <= '0;
         gnt_q            <= '0;
         resp_valid_q     <= '0;
         resp_quotient_q  <= '0;
         resp_remainder_q <= '0;
         resp_error_q     <= 1'b0;
         resp_timeout_q   <= 1'b0;
         busy_q           <= 1'b0;
         div_start_q      <= 1'b0;
         div_abort_q      <= 1'b0;
         div_dividend_q   <= '0;
         div_divisor_q    <= '0;
      end else begin
         // Pulse outputs fall back to zero unless a state re-asserts them.
         gnt_q        <= '0;
         resp_valid_q <= '0;
         div_start_q  <= 1'b0;
         div_abort_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  owner_q          <= win_idx;
                  gnt_q[win_idx]   <= 1'b1;
                  div_dividend_q   <= bus.dividend_in[win_idx*WIDTH +: WIDTH];
                  div_divisor_q    <= bus.divisor_in[win_idx*WIDTH +: WIDTH];
                  busy_q           <= 1'b1;
                  state_q          <= ISSUE;
               end
            end
            ISSUE: begin
               div_start_q <= 1'b1;
               timer_q     <= '0;
               state_q     <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // A done arriving on the watchdog's last cycle still wins.
               if (bus.div_done) begin
                  resp_quotient_q       <= bus.div_quotient;
                  resp_remainder_q      <= bus.div_remainder;
                  resp_error_q          <= bus.div_error;
                  resp_timeout_q        <= 1'b0;
                  resp_valid_q[owner_q] <= 1'b1;
                  state_q               <= RESPOND;
               end else if (timer_q == TMAX) begin
                  div_abort_q           <= 1'b1;
                  resp_quotient_q       <= '0;
                  resp_remainder_q      <= '0;
                  resp_error_q          <= 1'b1;
                  resp_timeout_q        <= 1'b1;
                  resp_valid_q[owner_q] <= 1'b1;
                  state_q               <= RESPOND;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            RESPOND: begin
               // Priority moves past the owner so a held request cannot starve others.
               rr_ptr_q <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt            = gnt_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_quotient  = resp_quotient_q;
   assign bus.resp_remainder = resp_remainder_q;
   assign bus.resp_error     = resp_error_q;
   assign bus.resp_timeout   = resp_timeout_q;
   assign bus.busy           = busy_q;
   assign bus.div_start      = div_start_q;
   assign bus.div_abort      = div_abort_q;
   assign bus.div_dividend   = div_dividend_q;
   assign bus.div_divisor    = div_divisor_q;
   assign state_o            = state_q;
   assign rr_ptr_o           = rr_ptr_q;
endmodule

// File: tb/tb_div_request_arbiter.sv
// ----------------------------------------------------------------------------
// tb_div_request_arbiter
// Directed bench for div_request_arbiter with NREQ=4, WIDTH=8, TIMEOUT=16.
// A behavioural divider answers div_start after a programmable latency (or
// never, in hang mode).  Expected grants and responses are queued when the
// stimulus is driven and compared when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_div_request_arbiter;
   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;
   localparam int RW      = 2 + 2*WIDTH + 2;   // {owner, quotient, remainder, error, timeout}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_request_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
   logic [1:0] state_dbg;
   logic [1:0] rr_dbg;

   div_request_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus      (bus),
      .state_o  (state_dbg),
      .rr_ptr_o (rr_dbg)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [RW-1:0]   exp_q[$];
   logic [NREQ-1:0] exp_gnt_q[$];
   int cyc = 0;
   int start_cyc = 0;
   int abort_seen = 0;
   logic [NREQ-1:0] prev_gnt = '0;
   logic [RW-1:0]   mon_e;
   logic [NREQ-1:0] mon_oh;

   // divider model controls
   logic hang_mode = 1'b0;
   int   div_lat   = 2;
   int   div_cnt   = 0;
   logic [WIDTH-1:0] div_a = '0;
   logic [WIDTH-1:0] div_b = '0;
   logic hold_all = 1'b0;
   int   idle_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] exp_div(input int i, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {2'(i), q, r, (b == '0), 1'b0};
   endfunction

   // ---------------- divider model ----------------
   initial begin
      bus.div_done      = 1'b0;
      bus.div_error     = 1'b0;
      bus.div_quotient  = '0;
      bus.div_remainder = '0;
      forever begin
         @(negedge clk);
         bus.div_done      = 1'b0;
         bus.div_error     = 1'b0;
         bus.div_quotient  = '0;
         bus.div_remainder = '0;
         if (!rst_n || bus.div_abort) begin
            div_cnt = 0;
         end else if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin
               bus.div_done = 1'b1;
               if (div_b == '0) begin
                  bus.div_error     = 1'b1;
                  bus.div_quotient  = '1;
                  bus.div_remainder = div_a;
               end else begin
                  bus.div_quotient  = div_a / div_b;
                  bus.div_remainder = div_a % div_b;
               end
            end
         end
         if (rst_n && bus.div_start && !hang_mode) begin
            div_a   = bus.div_dividend;
            div_b   = bus.div_divisor;
            div_cnt = div_lat;
         end
      end
   end

   // ---------------- output monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_gnt = '0;
         end else begin
            if (bus.gnt !== '0) begin
               check("gnt_expected", exp_gnt_q.size() != 0, 1'b1);
               if (exp_gnt_q.size() != 0) begin
                  mon_oh = exp_gnt_q.pop_front();
                  check("gnt_onehot", bus.gnt, mon_oh);
               end
            end
            check("div_start_after_gnt", bus.div_start, prev_gnt != '0);
            if (bus.div_start) start_cyc = cyc;
            if (bus.div_abort) begin
               abort_seen++;
               check("abort_delay", cyc - start_cyc, TIMEOUT);
            end
            if (bus.resp_valid !== '0) begin
               check("resp_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  mon_e  = exp_q.pop_front();
                  mon_oh = '0;
                  mon_oh[mon_e[RW-1 -: 2]] = 1'b1;
                  check("resp_valid", bus.resp_valid, mon_oh);
                  check("resp_quotient", bus.resp_quotient, mon_e[2*WIDTH+1 -: WIDTH]);
                  check("resp_remainder", bus.resp_remainder, mon_e[WIDTH+1 -: WIDTH]);
                  check("resp_error", bus.resp_error, mon_e[1]);
                  check("resp_timeout", bus.resp_timeout, mon_e[0]);
               end
            end
            prev_gnt = bus.gnt;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.dividend_in[i*WIDTH +: WIDTH] = a;
      bus.divisor_in[i*WIDTH +: WIDTH]  = b;
   endtask

   task automatic rand_ops(input int i);
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(1, 255));
      set_ops(i, a, b);
   endtask

   function automatic logic [RW-1:0] exp_for(input int i);
      return exp_div(i, bus.dividend_in[i*WIDTH +: WIDTH], bus.divisor_in[i*WIDTH +: WIDTH]);
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, bus.gnt, '0);
      check({tag, "_resp_valid"}, bus.resp_valid, '0);
      check({tag, "_quotient"}, bus.resp_quotient, '0);
      check({tag, "_remainder"}, bus.resp_remainder, '0);
      check({tag, "_error"}, bus.resp_error, 1'b0);
      check({tag, "_timeout"}, bus.resp_timeout, 1'b0);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_start"}, bus.div_start, 1'b0);
      check({tag, "_abort"}, bus.div_abort, 1'b0);
      check({tag, "_dividend"}, bus.div_dividend, '0);
      check({tag, "_divisor"}, bus.div_divisor, '0);
      check({tag, "_state"}, state_dbg, 2'd0);
      check({tag, "_rr_ptr"}, rr_dbg, 2'd0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs until n responses are seen or max_cyc cycles pass; requesters drop
   // req once granted unless hold_all is set.
   task automatic run_ops(input int n, input int max_cyc);
      int got;
      int k;
      logic seen;
      got = 0;
      k = 0;
      seen = 1'b0;
      idle_cnt = 0;
      while (got < n && k < max_cyc) begin
         @(negedge clk);
         k++;
         if (bus.gnt !== '0) seen = 1'b1;
         if (seen && !bus.busy) idle_cnt++;
         if (!hold_all) bus.req = bus.req & ~bus.gnt;
         if (bus.resp_valid !== '0) begin
            got++;
            if (hold_all && got == n) bus.req = '0;
         end
      end
      check("responses_within_budget", got, n);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k;
      bus.req         = '0;
      bus.dividend_in = '0;
      bus.divisor_in  = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single request: 100 / 7 from requester 2.
      div_lat = 3;
      set_ops(2, 8'd100, 8'd7);
      exp_gnt_q.push_back(4'b0100);
      exp_q.push_back({2'd2, 8'd14, 8'd2, 1'b0, 1'b0});
      bus.req[2] = 1'b1;
      run_ops(1, 60);
      @(negedge clk);
      check("rr_after_single", rr_dbg, 2'd3);
      check("busy_in_idle", bus.busy, 1'b0);

      // Simultaneous requests 0 and 1 from rr_ptr=0.
      do_reset();
      div_lat = $urandom_range(1, 5);
      rand_ops(0);
      rand_ops(1);
      exp_gnt_q.push_back(4'b0001);
      exp_gnt_q.push_back(4'b0010);
      exp_q.push_back(exp_for(0));
      exp_q.push_back(exp_for(1));
      bus.req = 4'b0011;
      run_ops(2, 100);

      // Same pair with rr_ptr=1: requester 1 first.
      do_reset();
      rand_ops(0);
      exp_gnt_q.push_back(4'b0001);
      exp_q.push_back(exp_for(0));
      bus.req = 4'b0001;
      run_ops(1, 60);
      @(negedge clk);
      check("rr_before_pair", rr_dbg, 2'd1);
      rand_ops(0);
      rand_ops(1);
      exp_gnt_q.push_back(4'b0010);
      exp_gnt_q.push_back(4'b0001);
      exp_q.push_back(exp_for(1));
      exp_q.push_back(exp_for(0));
      bus.req = 4'b0011;
      run_ops(2, 100);

      // Saturation: all four hold req for 8 operations.
      do_reset();
      div_lat = $urandom_range(1, 4);
      for (int i = 0; i < NREQ; i++) rand_ops(i);
      for (int j = 0; j < 8; j++) begin
         exp_gnt_q.push_back(4'(1 << (j % NREQ)));
         exp_q.push_back(exp_for(j % NREQ));
      end
      hold_all = 1'b1;
      bus.req  = '1;
      run_ops(8, 400);
      hold_all = 1'b0;
      check("saturation_idle_cycles", idle_cnt, 7);

      // Divide by zero from requester 3 (rr_ptr now 0).
      set_ops(3, 8'd55, 8'd0);
      exp_gnt_q.push_back(4'b1000);
      exp_q.push_back({2'd3, 8'hFF, 8'd55, 1'b1, 1'b0});
      bus.req = 4'b1000;
      run_ops(1, 60);

      // Timeout: the divider never answers.
      hang_mode = 1'b1;
      rand_ops(1);
      exp_gnt_q.push_back(4'b0010);
      exp_q.push_back({2'd1, 8'd0, 8'd0, 1'b1, 1'b1});
      bus.req = 4'b0010;
      run_ops(1, 80);
      hang_mode = 1'b0;
      check("abort_pulse_count", abort_seen, 1);

      // Following request is served normally.
      div_lat = 2;
      rand_ops(2);
      exp_gnt_q.push_back(4'b0100);
      exp_q.push_back(exp_for(2));
      bus.req = 4'b0100;
      run_ops(1, 60);

      // Reset in the middle of WAIT_DONE: the pending operation is lost.
      hang_mode = 1'b1;
      rand_ops(0);
      exp_gnt_q.push_back(4'b0001);
      bus.req = 4'b0001;
      k = 0;
      while (bus.gnt === '0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("midreset_gnt_seen", bus.gnt, 4'b0001);
      bus.req = '0;
      repeat (4) @(negedge clk);
      check("midreset_in_wait", state_dbg, 2'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      repeat (2) @(negedge clk);
      hang_mode = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // After release rr_ptr=0: requester 1 beats requester 3.
      rand_ops(1);
      rand_ops(3);
      exp_gnt_q.push_back(4'b0010);
      exp_gnt_q.push_back(4'b1000);
      exp_q.push_back(exp_for(1));
      exp_q.push_back(exp_for(3));
      bus.req = 4'b1010;
      run_ops(2, 100);

      repeat (3) @(negedge clk);
      check("resp_queue_drained", exp_q.size(), 0);
      check("gnt_queue_drained", exp_gnt_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
